// File: rtl/synth_midi_pkg.sv
// rtl/synth_midi_pkg.sv - shared arbiter state type and MIDI byte-index constants
package synth_midi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    EMIT,
    GAP
  } arb_state_t;

  localparam logic [7:0] MIDI_NR_WRAP    = 8'd254;
  localparam logic [7:0] MIDI_NR_RESTART = 8'd1;

  // Index 0 is the status byte only; data bytes cycle 1..254 so parity keeps alternating.
  function automatic logic [7:0] next_midi_nr(input logic [7:0] nr);
    return (nr == MIDI_NR_WRAP) ? MIDI_NR_RESTART : nr + 8'd1;
  endfunction

endpackage

// File: rtl/midi_rr_pick.sv
// rtl/midi_rr_pick.sv - combinational round-robin picker: first requester at or after ptr
module midi_rr_pick #(
  parameter int NUM_SRC = 3,
  parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               found
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/midi_src_arbiter.sv
// rtl/midi_src_arbiter.sv - message-atomic round-robin arbiter onto the paced MIDI byte path
module midi_src_arbiter
  import synth_midi_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                   data_clk,
  input  logic                   reset_reg,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_grant,
  output logic [NUM_SRC-1:0]     src_ack,
  output logic                   byteready,
  output logic [7:0]             midibyte_nr,
  output logic [7:0]             midi_in_data,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_t         state, state_nxt;
  logic [IW-1:0]      rr_ptr, gnt_idx, pick_idx;
  logic [NUM_SRC-1:0] pick_grant;
  logic               pick_found;
  logic [WW-1:0]      wait_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [7:0]         nr_q;
  logic               last_q;
  logic               g_req, g_valid, g_last;
  logic [7:0]         g_data;
  logic               do_grant, do_latch, do_release, do_timeout, do_advance;

  midi_rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign g_req   = src_req[gnt_idx];
  assign g_valid = src_valid[gnt_idx];
  assign g_last  = src_last[gnt_idx];
  assign g_data  = src_data[8*gnt_idx +: 8];
  assign busy    = |src_grant;

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_latch   = 1'b0;
    do_release = 1'b0;
    do_timeout = 1'b0;
    do_advance = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          do_grant  = 1'b1;
          state_nxt = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        // A byte presented together with a req drop is still taken.
        if (g_valid) begin
          do_latch  = 1'b1;
          state_nxt = EMIT;
        end else if (!g_req) begin
          do_release = 1'b1;
          state_nxt  = IDLE;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          do_release = 1'b1;
          state_nxt  = IDLE;
        end
      end
      EMIT: state_nxt = GAP;
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          if (last_q) begin
            do_release = 1'b1;
            state_nxt  = IDLE;
          end else begin
            do_advance = 1'b1;
            state_nxt  = WAIT_BYTE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge data_clk or posedge reset_reg) begin
    if (reset_reg) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge data_clk or posedge reset_reg) begin
    if (reset_reg) begin
      src_grant    <= '0;
      src_ack      <= '0;
      byteready    <= 1'b0;
      midibyte_nr  <= '0;
      midi_in_data <= '0;
      timeout_err  <= 1'b0;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      nr_q         <= '0;
      last_q       <= 1'b0;
    end else begin
      byteready   <= do_latch;
      src_ack     <= do_latch ? src_grant : '0;
      timeout_err <= do_timeout;
      wait_cnt    <= (state == WAIT_BYTE) ? wait_cnt + WW'(1) : '0;
      gap_cnt     <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (do_grant) begin
        src_grant <= pick_grant;
        gnt_idx   <= pick_idx;
        nr_q      <= '0;
      end else if (do_release) begin
        src_grant <= '0;
        rr_ptr    <= (gnt_idx == IW'(NUM_SRC - 1)) ? '0 : gnt_idx + IW'(1);
      end
      if (do_advance) nr_q <= next_midi_nr(nr_q);
      // Output byte/index are loaded with the strobe and held until the next one.
      if (do_latch) begin
        midi_in_data <= g_data;
        midibyte_nr  <= nr_q;
        last_q       <= g_last;
      end
    end
  end

endmodule

// File: tb/tb_midi_src_arbiter.sv
// tb/tb_midi_src_arbiter.sv - randomized self-checking bench for midi_src_arbiter
module tb_midi_src_arbiter;

  localparam int NS  = 3;
  localparam int GAP = 4;
  localparam int TO  = 10;

  logic              data_clk  = 1'b0;
  logic              reset_reg = 1'b1;
  logic [NS-1:0]     src_req   = '0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS-1:0]     src_last  = '0;
  logic [8*NS-1:0]   src_data  = '0;
  logic [NS-1:0]     src_grant, src_ack;
  logic              byteready, busy, timeout_err;
  logic [7:0]        midibyte_nr, midi_in_data;

  midi_src_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .data_clk     (data_clk),
    .reset_reg    (reset_reg),
    .src_req      (src_req),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_last     (src_last),
    .src_grant    (src_grant),
    .src_ack      (src_ack),
    .byteready    (byteready),
    .midibyte_nr  (midibyte_nr),
    .midi_in_data (midi_in_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 data_clk = ~data_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Source models: each source owns a message buffer and walks through it on acks.
  logic [7:0] msg [NS][0:511];
  int len [NS], pos [NS], dly [NS], msgs_left [NS], drop_at [NS];
  bit stall [NS];
  int maxd = 0, idle_max = 0;
  bit rand_msgs = 1'b0;

  // Reference observations.
  int cyc = 0;
  int rr_ptr = 0;
  logic [NS-1:0] prev_grant = '0;
  logic [7:0] prev_nr = '0;
  int br_cnt, ack_cnt, to_cnt, to_cyc, last_br_cyc, bytes_sent;
  int br_cyc_q[$], grant_cyc_q[$], grant_order[$], rel_q[$];

  function automatic int enc(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NS-1:0] rr_expect(input logic [NS-1:0] req, input int ptr);
    for (int k = 0; k < NS; k++) if (req[(ptr + k) % NS]) return NS'(1) << ((ptr + k) % NS);
    return '0;
  endfunction

  function automatic int exp_nr(input int p);
    return (p == 0) ? 0 : ((p - 1) % 254) + 1;
  endfunction

  function automatic bit all_idle();
    int sum = 0;
    for (int s = 0; s < NS; s++) sum += msgs_left[s];
    return (sum == 0) && (src_req == '0) && (src_grant == '0);
  endfunction

  task automatic monitor();
    int g;
    if (src_grant !== prev_grant) begin
      check("grant_onehot", $onehot0(src_grant), 1);
      check("busy", busy, |src_grant);
      if (prev_grant != '0) begin
        check("release_idle", src_grant, 0);
        rr_ptr = (enc(prev_grant) + 1) % NS;
        rel_q.push_back(cyc);
      end else begin
        check("rr_grant", src_grant, rr_expect(src_req, rr_ptr));
        grant_cyc_q.push_back(cyc);
        grant_order.push_back(enc(src_grant));
      end
      prev_grant = src_grant;
    end
    if (byteready || (src_ack != '0)) begin
      check("ack_grant", src_ack, src_grant);
      check("br_with_ack", byteready, 1);
      g = enc(src_grant);
      if (g >= 0) begin
        check("data", midi_in_data, msg[g][pos[g]]);
        check("nr", midibyte_nr, exp_nr(pos[g]));
        if (pos[g] > 0) begin
          check("parity", midibyte_nr[0] ^ prev_nr[0], 1);
          check("spacing", (cyc - last_br_cyc) >= GAP + 2, 1);
        end
      end
      prev_nr = midibyte_nr;
      last_br_cyc = cyc;
      br_cyc_q.push_back(cyc);
      if (byteready) br_cnt++;
      if (src_ack != '0) ack_cnt++;
    end
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
  endtask

  task automatic drive_sources();
    for (int s = 0; s < NS; s++) begin
      if (src_ack[s]) begin
        pos[s]++;
        src_valid[s] = 1'b0;
        if (pos[s] >= len[s]) begin
          src_req[s] = 1'b0;
          msgs_left[s]--;
          bytes_sent += len[s];
        end else dly[s] = $urandom_range(maxd, 0);
      end
      if (!src_req[s] && msgs_left[s] > 0 && $urandom_range(idle_max, 0) == 0) begin
        if (rand_msgs) begin
          len[s] = $urandom_range(6, 1);
          for (int i = 0; i < len[s]; i++) msg[s][i] = 8'($urandom);
        end
        pos[s] = 0;
        src_req[s] = 1'b1;
        src_valid[s] = 1'b0;
        dly[s] = $urandom_range(maxd, 0);
      end
      if (src_req[s] && !src_valid[s] && !stall[s]) begin
        if (dly[s] == 0) begin
          src_valid[s] = 1'b1;
          src_data[8*s +: 8] = msg[s][pos[s]];
          src_last[s] = (pos[s] == len[s] - 1);
          if (pos[s] == drop_at[s]) begin
            src_req[s] = 1'b0;
            msgs_left[s] = 0;
          end
        end else dly[s]--;
      end
    end
  endtask

  task automatic tick();
    @(posedge data_clk);
    #1;
    cyc++;
    monitor();
    drive_sources();
  endtask

  task automatic clear_model();
    for (int s = 0; s < NS; s++) begin
      pos[s] = 0; len[s] = 0; dly[s] = 0; msgs_left[s] = 0; drop_at[s] = -1; stall[s] = 1'b0;
    end
    src_req = '0; src_valid = '0; src_last = '0; src_data = '0;
  endtask

  task automatic clear_stats();
    br_cnt = 0; ack_cnt = 0; to_cnt = 0; to_cyc = 0; bytes_sent = 0;
    br_cyc_q.delete(); grant_cyc_q.delete(); grant_order.delete(); rel_q.delete();
  endtask

  task automatic do_reset();
    reset_reg = 1'b1;
    clear_model();
    repeat (2) @(posedge data_clk);
    @(negedge data_clk);
    reset_reg = 1'b0;
    prev_grant = '0;
    rr_ptr = 0;
  endtask

  task automatic chk_zero(input string p);
    check({p, "_grant"}, src_grant, 0);
    check({p, "_ack"}, src_ack, 0);
    check({p, "_byteready"}, byteready, 0);
    check({p, "_nr"}, midibyte_nr, 0);
    check({p, "_data"}, midi_in_data, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_timeout"}, timeout_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_model();
    clear_stats();
    repeat (2) @(posedge data_clk);
    #1;
    chk_zero("rst");
    @(negedge data_clk);
    reset_reg = 1'b0;

    // Single source, 3-byte note-on with valid always high
    clear_stats();
    msg[0][0] = 8'h90; msg[0][1] = 8'h3C; msg[0][2] = 8'h64;
    len[0] = 3; msgs_left[0] = 1;
    for (int k = 0; k < 80 && rel_q.size() == 0; k++) tick();
    check("t1_release", rel_q.size(), 1);
    check("t1_bytes", br_cnt, 3);
    if (br_cyc_q.size() == 3 && grant_cyc_q.size() == 1 && rel_q.size() == 1) begin
      check("t1_latency", br_cyc_q[0] - grant_cyc_q[0], 1);
      check("t1_space01", br_cyc_q[1] - br_cyc_q[0], GAP + 2);
      check("t1_space12", br_cyc_q[2] - br_cyc_q[1], GAP + 2);
      check("t1_grant_drop", rel_q[0] - br_cyc_q[2], GAP + 1);
    end

    // Three simultaneous 1-byte realtime messages, src0 requests again
    do_reset();
    clear_stats();
    for (int s = 0; s < NS; s++) begin
      msg[s][0] = 8'hF8; len[s] = 1; msgs_left[s] = (s == 0) ? 2 : 1;
    end
    for (int k = 0; k < 100 && rel_q.size() < 4; k++) tick();
    check("t2_grants", grant_order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_order.size()) check("t2_order", grant_order[i], i % NS);
    check("t2_bytes", br_cnt, 4);

    // Granted source never presents a byte
    do_reset();
    clear_stats();
    stall[0] = 1'b1; msg[0][0] = 8'hF8; len[0] = 1; msgs_left[0] = 1;
    msg[1][0] = 8'hFE; len[1] = 1; msgs_left[1] = 1;
    for (int k = 0; k < 60 && to_cnt == 0; k++) tick();
    src_req[0] = 1'b0;
    msgs_left[0] = 0;
    for (int k = 0; k < 60 && rel_q.size() < 2; k++) tick();
    check("t3_timeouts", to_cnt, 1);
    if (grant_cyc_q.size() >= 2 && rel_q.size() >= 1) begin
      check("t3_timeout_at", to_cyc - grant_cyc_q[0], TO);
      check("t3_release_at", rel_q[0], to_cyc);
      check("t3_regrant", grant_cyc_q[1] - to_cyc, 1);
      check("t3_next_src", grant_order[1], 1);
    end else check("t3_grants", grant_cyc_q.size(), 2);

    // 300-byte sysex from src1
    clear_stats();
    for (int i = 0; i < 300; i++) msg[1][i] = 8'($urandom);
    len[1] = 300; msgs_left[1] = 1;
    for (int k = 0; k < 2500 && rel_q.size() == 0; k++) tick();
    check("t4_release", rel_q.size(), 1);
    check("t4_bytes", br_cnt, 300);
    check("t4_acks", ack_cnt, 300);

    // Asynchronous reset in the GAP after the second byte
    clear_stats();
    msg[0][0] = 8'h91; msg[0][1] = 8'h40; msg[0][2] = 8'h7F;
    len[0] = 3; msgs_left[0] = 1;
    for (int k = 0; k < 40 && br_cnt < 2; k++) tick();
    tick();
    tick();
    #2 reset_reg = 1'b1;
    #1 chk_zero("async_rst");
    do_reset();
    clear_stats();
    msg[0][0] = 8'hF8; len[0] = 1; msgs_left[0] = 1;
    msg[2][0] = 8'hFA; len[2] = 1; msgs_left[2] = 1;
    for (int k = 0; k < 60 && rel_q.size() < 2; k++) tick();
    check("t5_done", rel_q.size(), 2);
    if (grant_order.size() > 0) check("t5_first_src", grant_order[0], 0);

    // Byte presented on the same cycle the source drops req
    clear_stats();
    msg[0][0] = 8'hB0; msg[0][1] = 8'h07; msg[0][2] = 8'h55;
    len[0] = 3; msgs_left[0] = 1; drop_at[0] = 1;
    for (int k = 0; k < 60 && rel_q.size() == 0; k++) tick();
    check("t6_release", rel_q.size(), 1);
    check("t6_bytes", br_cnt, 2);
    check("t6_acks", ack_cnt, 2);
    check("t6_no_timeout", to_cnt, 0);
    if (br_cyc_q.size() == 2 && rel_q.size() == 1)
      check("t6_release_at", rel_q[0] - br_cyc_q[1], GAP + 2);

    // Random traffic from all sources
    clear_stats();
    drop_at[0] = -1;
    rand_msgs = 1'b1; maxd = 3; idle_max = 3;
    for (int s = 0; s < NS; s++) msgs_left[s] = 8;
    for (int k = 0; k < 6000 && !all_idle(); k++) tick();
    check("t7_done", all_idle(), 1);
    check("t7_no_timeout", to_cnt, 0);
    check("t7_bytes", br_cnt, bytes_sent);
    check("t7_acks", ack_cnt, br_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
